// File: rtl/eeg_pack_pkg.sv
// Shared types and constants for the EEG block packer: FSM state type, block
// and length widths, and the lanes-per-block helper.
package eeg_pack_pkg;

    localparam int BLOCK_W = 128;
    localparam int LEN_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2,
        ST_DROP = 2'd3
    } pack_state_e;

    function automatic int lanes_f(input int sample_w);
        return BLOCK_W / sample_w;
    endfunction

endpackage

// File: rtl/eeg_block_packer.sv
// Packs EEG samples into 128-bit blocks for the encryptor, MSB lane first,
// zero-padding the final block and truncating records beyond MAX_BLOCKS.
// Optional idle flush of a partial block: define EEG_PACK_TIMEOUT_EN.
module eeg_block_packer
    import eeg_pack_pkg::*;
#(
    parameter int SAMPLE_W       = 16,
    parameter int MAX_BLOCKS     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_sample,
    input  logic                s_last,
    output logic                rec_start,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BLOCK_W-1:0]  m_data,
    output logic                m_last,
    output logic [LEN_W-1:0]    m_len,
    output logic                truncated,
    output logic                busy
);

    localparam int LANES  = lanes_f(SAMPLE_W);
    localparam int LANE_W = $clog2(LANES);
    localparam int BLK_W  = $clog2(MAX_BLOCKS + 1);
    localparam int SCNT_W = $clog2(MAX_BLOCKS * LANES + 1);

    pack_state_e                         state_q, state_d;
    logic [LANES-1:0][SAMPLE_W-1:0]      buf_q, buf_d;
    logic [LANE_W-1:0]                   lane_q, lane_d;
    logic [BLK_W-1:0]                    blk_q, blk_d;
    logic [SCNT_W-1:0]                   scnt_q, scnt_d;
    logic                                last_seen_q, last_seen_d;
    logic                                m_valid_q, m_valid_d;
    logic                                m_last_q, m_last_d;
    logic [LEN_W-1:0]                    m_len_q, m_len_d;
    logic                                rec_start_q, rec_start_d;
    logic                                trunc_q, trunc_d;

    logic accept;
    logic tmo_hit;
    logic go_emit;
    logic emit_last;

    assign s_ready = (state_q != ST_EMIT);
    assign accept  = s_valid && s_ready;

`ifdef EEG_PACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts consecutive FILL cycles without an accepted sample.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_FILL && !accept)
            tmo_d = tmo_q + TMO_W'(1);
    end

    assign tmo_hit = (state_q == ST_FILL) && !accept &&
                     (tmo_d == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    logic tmo_unused;
    assign tmo_unused = |TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        lane_d      = lane_q;
        blk_d       = blk_q;
        scnt_d      = scnt_q;
        last_seen_d = last_seen_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_len_d     = m_len_q;
        rec_start_d = 1'b0;
        trunc_d     = 1'b0;
        go_emit     = 1'b0;
        emit_last   = 1'b0;

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept) begin
                    buf_d[LANE_W'(LANES-1) - lane_q] = s_sample;
                    scnt_d = scnt_q + SCNT_W'(1);
                    if (state_q == ST_IDLE)
                        rec_start_d = 1'b1;
                    if (lane_q == LANE_W'(LANES-1) || s_last) begin
                        go_emit   = 1'b1;
                        emit_last = s_last;
                    end else begin
                        lane_d  = lane_q + LANE_W'(1);
                        state_d = ST_FILL;
                    end
                end else if (tmo_hit) begin
                    go_emit   = 1'b1;
                    emit_last = 1'b1;
                end
            end
            ST_EMIT: begin
                if (m_ready) begin
                    buf_d     = '0;
                    lane_d    = '0;
                    blk_d     = blk_q + BLK_W'(1);
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q && !last_seen_q) begin
                        state_d = ST_DROP;
                        trunc_d = 1'b1;
                    end else if (m_last_q) begin
                        state_d     = ST_IDLE;
                        blk_d       = '0;
                        scnt_d      = '0;
                        last_seen_d = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_DROP: begin
                // Tail of an over-long record: swallow until its end marker.
                if (accept && s_last) begin
                    state_d     = ST_IDLE;
                    blk_d       = '0;
                    scnt_d      = '0;
                    last_seen_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_emit) begin
            state_d     = ST_EMIT;
            m_valid_d   = 1'b1;
            m_len_d     = LEN_W'(scnt_d) * LEN_W'(SAMPLE_W);
            m_last_d    = emit_last || (blk_q == BLK_W'(MAX_BLOCKS - 1));
            last_seen_d = emit_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            lane_q      <= '0;
            blk_q       <= '0;
            scnt_q      <= '0;
            last_seen_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_len_q     <= '0;
            rec_start_q <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            lane_q      <= lane_d;
            blk_q       <= blk_d;
            scnt_q      <= scnt_d;
            last_seen_q <= last_seen_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_len_q     <= m_len_d;
            rec_start_q <= rec_start_d;
            trunc_q     <= trunc_d;
        end
    end

    assign m_data    = buf_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_len     = m_len_q;
    assign rec_start = rec_start_q;
    assign truncated = trunc_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eeg_block_packer.sv
// Scoreboard bench for eeg_block_packer: a list-based record model predicts
// blocks, a negedge monitor pops and compares every accepted block.
module tb_eeg_block_packer;

    localparam int SW    = 16;
    localparam int MAXB  = 2;
    localparam int TMO   = 16;
    localparam int LANES = 128 / SW;
    localparam int CAP   = MAXB * LANES;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_last;
    logic [SW-1:0] s_sample;
    logic          rec_start, m_valid, m_ready, m_last, truncated, busy;
    logic [127:0]  m_data;
    logic [63:0]   m_len;

    always #5 clk = ~clk;

    eeg_block_packer #(.SAMPLE_W(SW), .MAX_BLOCKS(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_sample(s_sample), .s_last(s_last),
        .rec_start(rec_start),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_len(m_len), .truncated(truncated), .busy(busy)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [63:0]  len;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0;
    int   rec_seen = 0, trunc_seen = 0, exp_rec = 0, exp_trunc = 0;
    int   stall_left = 0;
    bit   rand_rdy = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: sample away from the active edge and score every handshake.
    exp_t         mon_e;
    logic [127:0] hd;
    logic [63:0]  hl;
    logic         hlast;
    bit           hold = 0;

    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (rec_start) rec_seen++;
            if (truncated) trunc_seen++;
            if (m_valid) begin
                chk("s_ready_low_in_emit", s_ready, 0);
                if (hold) begin
                    chk("hold_data", m_data, hd);
                    chk("hold_len", m_len, hl);
                    chk("hold_last", m_last, hlast);
                end
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_block: got %h expected no block", m_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("blk_data", m_data, mon_e.data);
                        chk("blk_last", m_last, mon_e.last);
                        chk("blk_len", m_len, mon_e.len);
                    end
                    hold = 0;
                end else begin
                    hold  = 1;
                    hd    = m_data;
                    hl    = m_len;
                    hlast = m_last;
                end
            end else begin
                hold = 0;
            end
        end
    end

    // Downstream ready: directed stall, random, or always ready.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && m_valid) begin
                m_ready = 1'b0;
                stall_left--;
            end else if (rand_rdy) begin
                m_ready = ($urandom_range(0, 2) != 0);
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    task automatic put(input logic [SW-1:0] d, input logic l, input int gap);
        int t = 0;
        s_valid  = 1'b1;
        s_sample = d;
        s_last   = l;
        @(negedge clk);
        while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got s_ready=0 for %0d cycles expected acceptance", t);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: slice the record into LANES-wide groups, capped at CAP samples.
    task automatic send_record(input int n, input logic [SW-1:0] first, input bit seq, input int gapmax);
        logic [SW-1:0] smp[$];
        exp_t e;
        int   kept, nb, cnt;
        for (int i = 0; i < n; i++)
            smp.push_back(seq ? SW'(32'(first) + i) : SW'($urandom));
        kept = (n < CAP) ? n : CAP;
        nb   = (kept + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int k = 0; k < LANES; k++)
                if (b * LANES + k < kept)
                    e.data[127 - SW*k -: SW] = smp[b * LANES + k];
            cnt    = ((b + 1) * LANES < kept) ? (b + 1) * LANES : kept;
            e.last = (b == nb - 1);
            e.len  = 64'(cnt * SW);
            exp_q.push_back(e);
        end
        exp_rec++;
        if (n > CAP) exp_trunc++;
        for (int i = 0; i < n; i++)
            put(smp[i], i == n - 1, $urandom_range(0, gapmax));
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({nm, "_drained"}, (t < 2000), 1);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_m_valid"}, m_valid, 0);
        chk({nm, "_m_last"}, m_last, 0);
        chk({nm, "_rec_start"}, rec_start, 0);
        chk({nm, "_truncated"}, truncated, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_m_data"}, m_data, 0);
        chk({nm, "_m_len"}, m_len, 0);
        chk({nm, "_s_ready"}, s_ready, 1);
    endtask

    initial begin
        exp_t e;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_sample = '0;
        s_last   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("after_reset");

        // Single full block, two-block record with padding.
        send_record(8, 16'h0001, 1, 0);
        drain("one_block");
        send_record(11, 16'h0001, 1, 1);
        drain("two_block");

        // Five-cycle stall on the first block of an exactly-full record.
        stall_left = 5;
        send_record(16, 16'h0100, 1, 0);
        drain("backpressure");
        chk("stall_consumed", stall_left, 0);

        // Over-long record, then a fresh record starting at lane 0.
        send_record(20, 16'h0200, 1, 0);
        drain("truncation");
        chk("trunc_pulses", trunc_seen, 1);
        send_record(8, 16'h0300, 1, 0);
        drain("after_trunc");

        // Reset in the middle of a partial block.
        exp_rec++;
        put(16'h0E01, 0, 0);
        put(16'h0E02, 0, 0);
        put(16'h0E03, 0, 2);
        rst = 1'b1;
        #1;
        check_reset("mid_fill_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_record(8, 16'h0400, 1, 0);
        drain("after_reset_rec");

        // Idle gap inside a record.
        e.data = {16'hAAAA, 16'hBBBB, 16'hCCCC, 80'h0};
        exp_rec++;
`ifdef EEG_PACK_TIMEOUT_EN
        e.last = 1'b1;
        e.len  = 64'd48;
        exp_q.push_back(e);
        put(16'hAAAA, 0, 0);
        put(16'hBBBB, 0, 0);
        put(16'hCCCC, 0, 0);
        repeat (TMO + 8) @(posedge clk);
        #1;
        drain("timeout_flush");
`else
        e.data[79:64] = 16'hDDDD;
        e.last = 1'b1;
        e.len  = 64'd64;
        exp_q.push_back(e);
        put(16'hAAAA, 0, 0);
        put(16'hBBBB, 0, 0);
        put(16'hCCCC, 0, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("no_timeout_block", exp_q.size(), 1);
        chk("still_busy", busy, 1);
        put(16'hDDDD, 1, 0);
        drain("no_timeout");
`endif

        // Random records with random downstream stalls.
        rand_rdy = 1;
        for (int r = 0; r < 40; r++)
            send_record($urandom_range(1, 24), 16'h0000, 0, 3);
        drain("random");
        rand_rdy = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rec_start_count", rec_seen, exp_rec);
        chk("truncated_count", trunc_seen, exp_trunc);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
